// File: rtl/lcd_id_reader_pkg.sv
// lcd_pkg: panel ID constants, strap bit positions, FSM state type
// and the strap-code decoder shared by the LCD ID reader.
package lcd_pkg;

    localparam logic [15:0] LCD_ID_4342 = 16'h4342;
    localparam logic [15:0] LCD_ID_7084 = 16'h7084;
    localparam logic [15:0] LCD_ID_7016 = 16'h7016;
    localparam logic [15:0] LCD_ID_4384 = 16'h4384;
    localparam logic [15:0] LCD_ID_1018 = 16'h1018;
    localparam logic [15:0] LCD_ID_DEF  = LCD_ID_4342;

    localparam int M0_BIT = 7;
    localparam int M1_BIT = 15;
    localparam int M2_BIT = 23;

    typedef enum logic [1:0] {
        SETTLE,
        SAMPLE,
        DONE
    } state_t;

    typedef struct packed {
        logic        fallback;
        logic [15:0] id;
    } decode_t;

    function automatic int cnt_w(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

    // {M2,M1,M0} -> panel ID; unused codes fall back to the default
    function automatic decode_t decode_strap(
        input logic [2:0] m
    );
        decode_t d;
        d.fallback = 1'b0;
        d.id       = LCD_ID_DEF;
        case (m)
            3'b000:  d.id = LCD_ID_4342;
            3'b001:  d.id = LCD_ID_7084;
            3'b010:  d.id = LCD_ID_7016;
            3'b100:  d.id = LCD_ID_4384;
            3'b101:  d.id = LCD_ID_1018;
            default: d.fallback = 1'b1;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/lcd_id_reader_if.sv
// lcd_id_if: LCD pin sampling inputs and the decoded-ID outputs.
// master = the ID reader, slave = pin buffers / lcd_id consumers.
interface lcd_id_if;

    logic [23:0] lcd_rgb_in;
    logic        redetect;
    logic        lcd_rgb_oe;
    logic [15:0] lcd_id;
    logic        id_valid;
    logic        id_fallback;
    logic        busy;

    modport master (
        input  lcd_rgb_in,
        input  redetect,
        output lcd_rgb_oe,
        output lcd_id,
        output id_valid,
        output id_fallback,
        output busy
    );

    modport slave (
        output lcd_rgb_in,
        output redetect,
        input  lcd_rgb_oe,
        input  lcd_id,
        input  id_valid,
        input  id_fallback,
        input  busy
    );

endinterface

// File: rtl/lcd_id_reader_sync.sv
// lcd_strap_sync: 3-bit two-flop synchronizer for the strap pins.
// Ports: clk, rst_n (async low), i_m raw straps, o_m synchronized.
module lcd_strap_sync (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [2:0] i_m,
    output logic [2:0] o_m
);

    logic [2:0] r_s1;
    logic [2:0] r_s2;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1 <= '0;
            r_s2 <= '0;
        end else begin
            r_s1 <= i_m;
            r_s2 <= r_s1;
        end
    end

    assign o_m = r_s2;

endmodule

// File: rtl/lcd_id_reader.sv
// lcd_id_reader: releases the RGB pins, samples the M2/M1/M0 straps
// until stable and decodes the attached panel into lcd_id.
// Ports: clk, rst_n (async low), bus (lcd_id_if.master).
module lcd_id_reader
    import lcd_pkg::*;
#(
    parameter int SETTLE_CYC  = 1000,
    parameter int STABLE_CNT  = 16,
    parameter int TIMEOUT_CYC = 65536
) (
    input  logic     clk,
    input  logic     rst_n,
    lcd_id_if.master bus
);

    localparam int SW = cnt_w(SETTLE_CYC);
    localparam int KW = cnt_w(STABLE_CNT);
    localparam int TW = cnt_w(TIMEOUT_CYC);

    localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE_CYC - 1);
    localparam logic [KW-1:0] STABLE_LAST = KW'(STABLE_CNT - 1);
    localparam logic [TW-1:0] TMO_LAST    = TW'(TIMEOUT_CYC - 1);

    logic [2:0]    w_m_raw;
    logic [2:0]    w_m_sync;
    logic          w_match;
    decode_t       w_dec;
    // only the three strap bits are sampled; the rest is the RGB bus
    logic          w_unused;

    state_t        r_state;
    logic [SW-1:0] r_settle_cnt;
    logic [KW-1:0] r_stable_cnt;
    logic [TW-1:0] r_tmo_cnt;
    logic [2:0]    r_m_prev;
    logic [15:0]   r_lcd_id;
    logic          r_fallback;
    logic          r_valid;

    state_t        w_state_nxt;
    logic [SW-1:0] w_settle_nxt;
    logic [KW-1:0] w_stable_nxt;
    logic [TW-1:0] w_tmo_nxt;
    logic [2:0]    w_prev_nxt;
    logic [15:0]   w_id_nxt;
    logic          w_fb_nxt;
    logic          w_valid_nxt;

    assign w_m_raw = {
        bus.lcd_rgb_in[M2_BIT],
        bus.lcd_rgb_in[M1_BIT],
        bus.lcd_rgb_in[M0_BIT]
    };

    assign w_unused = ^bus.lcd_rgb_in;

    lcd_strap_sync u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .i_m   (w_m_raw),
        .o_m   (w_m_sync)
    );

    assign w_match = (w_m_sync == r_m_prev);
    assign w_dec   = decode_strap(r_m_prev);

    always_comb begin
        w_state_nxt  = r_state;
        w_settle_nxt = r_settle_cnt;
        w_stable_nxt = r_stable_cnt;
        w_tmo_nxt    = r_tmo_cnt;
        w_prev_nxt   = r_m_prev;
        w_id_nxt     = r_lcd_id;
        w_fb_nxt     = r_fallback;
        w_valid_nxt  = r_valid;
        unique case (r_state)
            SETTLE: begin
                if (r_settle_cnt == SETTLE_LAST) begin
                    w_state_nxt  = SAMPLE;
                    w_settle_nxt = '0;
                    w_prev_nxt   = w_m_sync;
                    w_stable_nxt = '0;
                    w_tmo_nxt    = '0;
                end else begin
                    w_settle_nxt = r_settle_cnt + SW'(1);
                end
            end
            SAMPLE: begin
                // a stable code beats a timeout on the same cycle
                if (w_match && r_stable_cnt == STABLE_LAST) begin
                    w_state_nxt = DONE;
                    w_id_nxt    = w_dec.id;
                    w_fb_nxt    = w_dec.fallback;
                    w_valid_nxt = 1'b1;
                end else if (r_tmo_cnt == TMO_LAST) begin
                    w_state_nxt = DONE;
                    w_id_nxt    = LCD_ID_DEF;
                    w_fb_nxt    = 1'b1;
                    w_valid_nxt = 1'b1;
                end else begin
                    w_tmo_nxt = r_tmo_cnt + TW'(1);
                    if (w_match) begin
                        w_stable_nxt = r_stable_cnt + KW'(1);
                    end else begin
                        w_stable_nxt = '0;
                        w_prev_nxt   = w_m_sync;
                    end
                end
            end
            DONE: begin
                // lcd_id is kept until the next decode replaces it
                if (bus.redetect) begin
                    w_state_nxt = SETTLE;
                    w_fb_nxt    = 1'b0;
                    w_valid_nxt = 1'b0;
                end
            end
            default: begin
                w_state_nxt = SETTLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= SETTLE;
            r_settle_cnt <= '0;
            r_stable_cnt <= '0;
            r_tmo_cnt    <= '0;
            r_m_prev     <= '0;
            r_lcd_id     <= '0;
            r_fallback   <= 1'b0;
            r_valid      <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_settle_cnt <= w_settle_nxt;
            r_stable_cnt <= w_stable_nxt;
            r_tmo_cnt    <= w_tmo_nxt;
            r_m_prev     <= w_prev_nxt;
            r_lcd_id     <= w_id_nxt;
            r_fallback   <= w_fb_nxt;
            r_valid      <= w_valid_nxt;
        end
    end

    assign bus.lcd_rgb_oe  = (r_state == DONE);
    assign bus.busy        = (r_state != DONE);
    assign bus.lcd_id      = r_lcd_id;
    assign bus.id_valid    = r_valid;
    assign bus.id_fallback = r_fallback;

endmodule
